// File: rtl/fallback_queue_cfg_ctrl_pkg.sv
// Shared types and helpers for the fallback-queue configuration controller.
// Holds the update FSM states, the metadata word and the setting legality check.
package fallback_queue_cfg_ctrl_pkg;

  localparam int DEFAULT_MAX_FALLBACK_QUEUES = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } fallback_cfg_state_t;

  typedef struct packed {
    logic [15:0] flow_id;
    logic [11:0] queue_id;
    logic        matched;
    logic [2:0]  prio;
  } metadata_t;

  // Zero means "drop unmatched"; otherwise a power of two no larger than max_nb.
  function automatic logic nb_is_legal(input logic [31:0] nb, input logic [31:0] max_nb);
    return (nb == 32'd0) || (((nb & (nb - 32'd1)) == 32'd0) && (nb <= max_nb));
  endfunction

endpackage

// File: rtl/fallback_queue_cfg_ctrl_if.sv
// Metadata stream (in and out) plus the config write channel of the controller.
// master = the side that feeds metadata and issues writes; slave = the controller.
interface fallback_queue_cfg_ctrl_if;

  fallback_queue_cfg_ctrl_pkg::metadata_t in_meta_data;
  logic                                   in_meta_valid;
  logic                                   in_meta_ready;
  fallback_queue_cfg_ctrl_pkg::metadata_t out_meta_data;
  logic                                   out_meta_valid;
  logic                                   out_meta_ready;
  logic                                   cfg_wr_valid;
  logic [31:0]                            cfg_wr_data;
  logic                                   cfg_wr_ready;

  modport master (
    output in_meta_data, in_meta_valid, out_meta_ready, cfg_wr_valid, cfg_wr_data,
    input  in_meta_ready, out_meta_data, out_meta_valid, cfg_wr_ready
  );

  modport slave (
    input  in_meta_data, in_meta_valid, out_meta_ready, cfg_wr_valid, cfg_wr_data,
    output in_meta_ready, out_meta_data, out_meta_valid, cfg_wr_ready
  );

endinterface

// File: rtl/fallback_queue_cfg_ctrl_inflight_counter.sv
// Saturating up/down count of packets handed to the flow director but not yet retired.
// A retire pulse at zero leaves the count at zero and raises a sticky underflow flag.
module inflight_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         underflow
);

  logic [W-1:0] count_q, count_d;
  logic         underflow_q, underflow_d;

  always_comb begin
    count_d     = count_q;
    underflow_d = underflow_q;
    if (inc && !dec) begin
      if (count_q != '1) count_d = count_q + W'(1);
    end else if (dec && !inc) begin
      if (count_q == '0) underflow_d = 1'b1;
      else               count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/fallback_queue_cfg_ctrl.sv
// Owns nb_fallback_queues: a legal write closes the metadata gate, drains in-flight
// packets (or times out), applies the new value in one APPLY cycle, then reopens.
module fallback_queue_cfg_ctrl
  import fallback_queue_cfg_ctrl_pkg::*;
#(
  parameter int MAX_FALLBACK_QUEUES = DEFAULT_MAX_FALLBACK_QUEUES,
  parameter int INFLIGHT_W          = 16,
  parameter int DRAIN_TIMEOUT       = 4096,
  parameter int RESET_NB_FALLBACK   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  fallback_queue_cfg_ctrl_if.slave      bus,
  input  logic                          pkt_done,
  output logic [31:0]                   nb_fallback_queues,
  output logic                          cfg_done,
  output logic                          cfg_err,
  output logic                          cfg_timeout,
  output logic                          inflight_underflow
);

  localparam int TIMER_W = $clog2(DRAIN_TIMEOUT + 1);

  fallback_cfg_state_t   state_q, state_d;
  logic [31:0]           pending_q, pending_d;
  logic [31:0]           nb_q, nb_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  cfg_timeout_q, cfg_timeout_d;
  logic                  gate_open;
  logic                  meta_hs;
  logic                  cfg_accept;
  logic                  req_legal;
  logic [INFLIGHT_W-1:0] inflight;

  inflight_counter #(.W(INFLIGHT_W)) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .inc       (meta_hs),
    .dec       (pkt_done),
    .count     (inflight),
    .underflow (inflight_underflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      nb_q          <= 32'(RESET_NB_FALLBACK);
      timer_q       <= '0;
      cfg_err_q     <= 1'b0;
      cfg_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      nb_q          <= nb_d;
      timer_q       <= timer_d;
      cfg_err_q     <= cfg_err_d;
      cfg_timeout_q <= cfg_timeout_d;
    end
  end

  // A stuck in-flight packet must not hold the update off forever, hence the timer.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    nb_d          = nb_q;
    timer_d       = timer_q;
    cfg_err_d     = 1'b0;
    cfg_timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_accept) begin
          if (req_legal) begin
            state_d   = DRAIN;
            pending_d = bus.cfg_wr_data;
            timer_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        timer_d = timer_q + TIMER_W'(1);
        if (inflight == '0) begin
          state_d = APPLY;
        end else if (timer_q == TIMER_W'(DRAIN_TIMEOUT - 1)) begin
          state_d       = APPLY;
          cfg_timeout_d = 1'b1;
        end
      end
      APPLY: begin
        nb_d    = pending_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gate_open          = (state_q == IDLE);
    bus.out_meta_data  = bus.in_meta_data;
    bus.out_meta_valid = gate_open & bus.in_meta_valid;
    bus.in_meta_ready  = gate_open & bus.out_meta_ready;
    bus.cfg_wr_ready   = gate_open & !(bus.in_meta_valid & !bus.out_meta_ready);
    cfg_done           = (state_q == APPLY);
  end

  assign meta_hs            = bus.out_meta_valid & bus.out_meta_ready;
  assign cfg_accept         = bus.cfg_wr_valid & bus.cfg_wr_ready;
  assign req_legal          = nb_is_legal(bus.cfg_wr_data, 32'(MAX_FALLBACK_QUEUES));
  assign nb_fallback_queues = nb_q;
  assign cfg_err            = cfg_err_q;
  assign cfg_timeout        = cfg_timeout_q;

endmodule

// File: tb/tb_fallback_queue_cfg_ctrl.sv
// Self-checking bench for fallback_queue_cfg_ctrl: directed update sequences, a table
// of config writes, then random traffic, all checked every cycle against a reference model.
module tb_fallback_queue_cfg_ctrl;
  import fallback_queue_cfg_ctrl_pkg::*;

  localparam int MAX_NB        = DEFAULT_MAX_FALLBACK_QUEUES;
  localparam int INFLIGHT_W    = 16;
  localparam int DRAIN_TIMEOUT = 4096;
  localparam int RESET_NB      = 0;
  localparam int INFLIGHT_MAX  = (1 << INFLIGHT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_done = 1'b0;
  logic [31:0] nb_fallback_queues;
  logic        cfg_done, cfg_err, cfg_timeout, inflight_underflow;

  fallback_queue_cfg_ctrl_if bus();

  fallback_queue_cfg_ctrl #(
    .MAX_FALLBACK_QUEUES (MAX_NB),
    .INFLIGHT_W          (INFLIGHT_W),
    .DRAIN_TIMEOUT       (DRAIN_TIMEOUT),
    .RESET_NB_FALLBACK   (RESET_NB)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .pkt_done           (pkt_done),
    .nb_fallback_queues (nb_fallback_queues),
    .cfg_done           (cfg_done),
    .cfg_err            (cfg_err),
    .cfg_timeout        (cfg_timeout),
    .inflight_underflow (inflight_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Inputs currently applied, as the bench drove them
  logic        cur_iv, cur_ordy, cur_pd, cur_cv;
  metadata_t   cur_data;
  logic [31:0] cur_cd;

  // Reference model: phase 0 = gate open, 1 = draining, 2 = applying
  int          m_phase;
  int          m_inflight;
  int          m_wait;
  logic [31:0] m_nb, m_pending;
  logic        m_under, m_err, m_to;

  // Last sampled DUT outputs, for the directed sequences
  logic        obs_out_valid, obs_in_ready, obs_cfg_ready, obs_done, obs_err, obs_to, obs_under;
  logic [31:0] obs_nb;

  typedef struct {
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_nb;
  } cfg_vec_t;

  cfg_vec_t    vecs[10];
  logic [31:0] picks[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic refLegal(input logic [31:0] d);
    return (d == 32'd0) || (($countones(d) == 1) && (d <= 32'(MAX_NB)));
  endfunction

  task automatic modelReset();
    m_phase    = 0;
    m_inflight = 0;
    m_wait     = 0;
    m_nb       = 32'(RESET_NB);
    m_pending  = 32'd0;
    m_under    = 1'b0;
    m_err      = 1'b0;
    m_to       = 1'b0;
  endtask

  task automatic modelStep();
    logic open, hs, acc;
    open  = (m_phase == 0);
    hs    = open & cur_iv & cur_ordy;
    acc   = cur_cv & open & !(cur_iv & !cur_ordy);
    m_err = acc & !refLegal(cur_cd);
    m_to  = 1'b0;
    if (m_phase == 0) begin
      if (acc && refLegal(cur_cd)) begin
        m_phase   = 1;
        m_pending = cur_cd;
        m_wait    = 0;
      end
    end else if (m_phase == 1) begin
      if (m_inflight == 0) m_phase = 2;
      else if (m_wait == DRAIN_TIMEOUT - 1) begin
        m_phase = 2;
        m_to    = 1'b1;
      end
      m_wait++;
    end else begin
      m_nb    = m_pending;
      m_phase = 0;
    end
    if (hs && !cur_pd) begin
      if (m_inflight < INFLIGHT_MAX) m_inflight++;
    end else if (cur_pd && !hs) begin
      if (m_inflight == 0) m_under = 1'b1;
      else m_inflight--;
    end
  endtask

  task automatic checkAll();
    logic open;
    open          = (m_phase == 0);
    obs_out_valid = bus.out_meta_valid;
    obs_in_ready  = bus.in_meta_ready;
    obs_cfg_ready = bus.cfg_wr_ready;
    obs_done      = cfg_done;
    obs_err       = cfg_err;
    obs_to        = cfg_timeout;
    obs_under     = inflight_underflow;
    obs_nb        = nb_fallback_queues;
    checkOutput("out_meta_valid", 32'(bus.out_meta_valid), 32'(open & cur_iv));
    checkOutput("in_meta_ready", 32'(bus.in_meta_ready), 32'(open & cur_ordy));
    checkOutput("cfg_wr_ready", 32'(bus.cfg_wr_ready), 32'(open & !(cur_iv & !cur_ordy)));
    checkOutput("out_meta_data", 32'(bus.out_meta_data), 32'(cur_data));
    checkOutput("nb_fallback_queues", nb_fallback_queues, m_nb);
    checkOutput("cfg_done", 32'(cfg_done), 32'(m_phase == 2));
    checkOutput("cfg_err", 32'(cfg_err), 32'(m_err));
    checkOutput("cfg_timeout", 32'(cfg_timeout), 32'(m_to));
    checkOutput("inflight_underflow", 32'(inflight_underflow), 32'(m_under));
  endtask

  task automatic driveInputs();
    bus.in_meta_valid  = cur_iv;
    bus.in_meta_data   = cur_data;
    bus.out_meta_ready = cur_ordy;
    bus.cfg_wr_valid   = cur_cv;
    bus.cfg_wr_data    = cur_cd;
    pkt_done           = cur_pd;
  endtask

  // One clock cycle: drive at the falling edge, check shortly after, model at the rising edge
  task automatic applyStimulus(input logic iv, input metadata_t d, input logic ordy,
                               input logic pd, input logic cv, input logic [31:0] cd);
    @(negedge clk);
    cur_iv = iv; cur_data = d; cur_ordy = ordy; cur_pd = pd; cur_cv = cv; cur_cd = cd;
    driveInputs();
    #1;
    checkAll();
    @(posedge clk);
    modelStep();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = 1'b1;
      cur_iv = 1'b0; cur_data = '0; cur_ordy = 1'b1; cur_pd = 1'b0; cur_cv = 1'b0; cur_cd = 32'd0;
      driveInputs();
      #1;
      modelReset();
      checkAll();
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    modelStep();
  endtask

  initial begin
    int hs_count, first_done, first_open, first_to, done_count;
    logic [31:0] nb_at_open;
    logic pd, iv;

    cur_iv = 1'b0; cur_data = '0; cur_ordy = 1'b1; cur_pd = 1'b0; cur_cv = 1'b0; cur_cd = 32'd0;
    driveInputs();
    modelReset();

    vecs[0] = '{32'd6,          1'b1, 32'd4};
    vecs[1] = '{32'd2048,       1'b1, 32'd4};
    vecs[2] = '{32'd0,          1'b0, 32'd0};
    vecs[3] = '{32'd1024,       1'b0, 32'd1024};
    vecs[4] = '{32'd1025,       1'b1, 32'd1024};
    vecs[5] = '{32'd3,          1'b1, 32'd1024};
    vecs[6] = '{32'd1,          1'b0, 32'd1};
    vecs[7] = '{32'h8000_0000,  1'b1, 32'd1};
    vecs[8] = '{32'd512,        1'b0, 32'd512};
    vecs[9] = '{32'd2,          1'b0, 32'd2};
    picks   = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd6, 32'd8, 32'd512, 32'd1024, 32'd2048};

    // 1: ten packets straight through, setting untouched
    doReset(3);
    checkOutput("t1_reset_nb", nb_fallback_queues, 32'(RESET_NB));
    hs_count = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, metadata_t'($urandom), 1'b1, 1'b0, 1'b0, 32'd0);
      if (obs_out_valid) hs_count++;
    end
    checkOutput("t1_handshakes", 32'(hs_count), 32'd10);
    checkOutput("t1_nb", obs_nb, 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 32'd0);
    idleCycle();
    checkOutput("t1_no_underflow", 32'(obs_under), 32'd0);

    // 2: write 8 with nothing in flight -> APPLY at T+2, visible at T+3
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'd8);
    applyStimulus(1'b1, metadata_t'($urandom), 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("t2_gate_closed_t1", 32'(obs_out_valid), 32'd0);
    applyStimulus(1'b1, metadata_t'($urandom), 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("t2_gate_closed_t2", 32'(obs_in_ready), 32'd0);
    checkOutput("t2_done_t2", 32'(obs_done), 32'd1);
    checkOutput("t2_nb_t2", obs_nb, 32'd0);
    idleCycle();
    checkOutput("t2_nb_t3", obs_nb, 32'd8);
    checkOutput("t2_gate_open_t3", 32'(obs_in_ready), 32'd1);

    // 3: three in flight, write 4, retires at +5, +9, +20
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, metadata_t'($urandom), 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'd4);
    first_done = 0; first_open = 0; nb_at_open = 32'd0;
    for (int k = 1; k <= 30; k++) begin
      pd = (k == 5) || (k == 9) || (k == 20);
      applyStimulus(1'b0, '0, 1'b1, pd, 1'b0, 32'd0);
      if (obs_done && first_done == 0) first_done = k;
      if (obs_in_ready && first_open == 0) begin
        first_open = k;
        nb_at_open = obs_nb;
      end
    end
    checkOutput("t3_done_cycle", 32'(first_done), 32'd22);
    checkOutput("t3_open_cycle", 32'(first_open), 32'd23);
    checkOutput("t3_nb", nb_at_open, 32'd4);

    // 4: table of writes with nothing in flight
    for (int v = 0; v < 10; v++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, vecs[v].data);
      idleCycle();
      checkOutput($sformatf("t4_err_%0h", vecs[v].data), 32'(obs_err), 32'(vecs[v].exp_err));
      checkOutput($sformatf("t4_gate_%0h", vecs[v].data), 32'(obs_in_ready), 32'(vecs[v].exp_err));
      idleCycle();
      checkOutput($sformatf("t4_done_%0h", vecs[v].data), 32'(obs_done), 32'(!vecs[v].exp_err));
      idleCycle();
      checkOutput($sformatf("t4_nb_%0h", vecs[v].data), obs_nb, vecs[v].exp_nb);
      checkOutput($sformatf("t4_ready_%0h", vecs[v].data), 32'(obs_cfg_ready), 32'd1);
    end

    // 5: two stuck packets, write 16 -> forced update after the drain timeout
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, metadata_t'($urandom), 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'd16);
    first_done = 0; first_open = 0; first_to = 0; nb_at_open = 32'd0;
    for (int k = 1; k <= DRAIN_TIMEOUT + 4; k++) begin
      idleCycle();
      if (obs_to && first_to == 0) first_to = k;
      if (obs_done && first_done == 0) first_done = k;
      if (obs_in_ready && first_open == 0) begin
        first_open = k;
        nb_at_open = obs_nb;
      end
    end
    checkOutput("t5_timeout_cycle", 32'(first_to), 32'(DRAIN_TIMEOUT + 1));
    checkOutput("t5_done_cycle", 32'(first_done), 32'(DRAIN_TIMEOUT + 1));
    checkOutput("t5_open_cycle", 32'(first_open), 32'(DRAIN_TIMEOUT + 2));
    checkOutput("t5_nb", nb_at_open, 32'd16);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 32'd0);

    // 6: reset in the middle of a drain with 32 pending
    applyStimulus(1'b1, metadata_t'($urandom), 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'd32);
    idleCycle();
    idleCycle();
    checkOutput("t6_in_drain", 32'(obs_in_ready), 32'd0);
    doReset(2);
    checkOutput("t6_nb_in_reset", obs_nb, 32'(RESET_NB));
    done_count = 0;
    for (int i = 0; i < 10; i++) begin
      idleCycle();
      if (obs_done) done_count++;
    end
    checkOutput("t6_no_apply", 32'(done_count), 32'd0);
    checkOutput("t6_nb_after", obs_nb, 32'(RESET_NB));
    checkOutput("t6_gate_open", 32'(obs_in_ready), 32'd1);

    // Underflow: retire with nothing in flight, count must stay at zero
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 32'd0);
    idleCycle();
    checkOutput("uf_flag", 32'(obs_under), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'd2);
    idleCycle();
    idleCycle();
    checkOutput("uf_fast_apply", 32'(obs_done), 32'd1);
    idleCycle();
    checkOutput("uf_nb", obs_nb, 32'd2);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset(1);
      iv = 1'($urandom_range(0, 1));
      pd = ($urandom_range(0, 2) == 0);
      applyStimulus(iv, metadata_t'($urandom), ($urandom_range(0, 3) != 0), pd,
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 4) == 0) ? $urandom : picks[$urandom_range(0, 9)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
